// File: rtl/pfd_loop_filter.sv
// pfd_loop_filter: PFD up/dn pulse measurement with a saturating PI update of a DCO control word.
// Define PFD_LF_LOCK_DET_EN to build the consecutive-update lock detector; otherwise lock is tied low.
module pfd_loop_filter #(
    parameter int CW        = 10,
    parameter int PW        = 6,
    parameter int KP_SHIFT  = 2,
    parameter int KI_SHIFT  = 3,
    parameter int CTRL_INIT = 512,
    parameter int LOCK_TOL  = 1,
    parameter int LOCK_CNT  = 8
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          en,
    input  logic          up,
    input  logic          dn,
    output logic [CW-1:0] ctrl,
    output logic          ctrl_vld,
    output logic          lock,
    output logic          sat
);
    localparam int AW = CW + KI_SHIFT + 1;
    localparam int SW = AW + PW + KP_SHIFT + 2;
    localparam logic signed [PW-1:0] EMAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MEAS, UPDATE} state_t;

    state_t                state;
    logic                  up_m, up_s, dn_m, dn_s;
    logic signed [PW-1:0]  err, err_inc;
    logic signed [AW-1:0]  acc, acc_new;
    logic signed [AW:0]    acc_sum;
    logic signed [SW-1:0]  sum;
    logic                  clamp;
    logic [CW-1:0]         ctrl_new;

    always_comb begin
        err_inc  = (up_s & ~dn_s) ? ((err == EMAX) ? err : err + ONE) :
                   (dn_s & ~up_s) ? ((err == -EMAX) ? err : err - ONE) : err;
        acc_sum  = (AW+1)'(acc) + (AW+1)'(err);
        acc_new  = (acc_sum[AW] != acc_sum[AW-1]) ? (acc_sum[AW] ? AMIN : AMAX) : acc_sum[AW-1:0];
        sum      = SW'(CTRL_INIT) + (SW'(err) <<< KP_SHIFT) + SW'(acc_new >>> KI_SHIFT);
        clamp    = sum[SW-1] | (|sum[SW-2:CW]);
        ctrl_new = sum[SW-1] ? '0 : (|sum[SW-2:CW]) ? '1 : sum[CW-1:0];
    end

    // err is zero whenever the FSM sits in IDLE, so err_inc there is just the entry cycle's step
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            {up_m, up_s, dn_m, dn_s} <= '0;
            state    <= IDLE;
            err      <= '0;
            acc      <= '0;
            ctrl     <= CW'(CTRL_INIT);
            ctrl_vld <= 1'b0;
            sat      <= 1'b0;
        end else begin
            {up_m, up_s} <= {up, up_m};
            {dn_m, dn_s} <= {dn, dn_m};
            ctrl_vld     <= 1'b0;
            case (state)
                IDLE: begin
                    state <= (en & (up_s | dn_s)) ? MEAS : IDLE;
                    err   <= (en & (up_s | dn_s)) ? err_inc : '0;
                end
                MEAS: begin
                    state <= !en ? IDLE : !(up_s | dn_s) ? UPDATE : MEAS;
                    err   <= !en ? '0 : err_inc;
                end
                UPDATE: begin
                    acc      <= acc_new;
                    ctrl     <= ctrl_new;
                    sat      <= clamp;
                    ctrl_vld <= 1'b1;
                    err      <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PFD_LF_LOCK_DET_EN
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0]        LMAX = LW'(LOCK_CNT);
    localparam logic signed [PW-1:0] TOL  = PW'(LOCK_TOL);

    logic [LW-1:0] lcnt;
    logic          in_lock;

    assign in_lock = (err <= TOL) && (err >= -TOL);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            lcnt <= '0;
            lock <= 1'b0;
        end else if (state == UPDATE) begin
            lcnt <= in_lock ? ((lcnt == LMAX) ? lcnt : lcnt + 1'b1) : '0;
            lock <= in_lock && (lcnt >= LMAX - 1'b1);
        end
    end
`else
    assign lock = 1'b0;
`endif
endmodule
